ftdi_bus_arbiter: RTL

// Schedules the shared FT245-style byte bus (dq) between host->FPGA reads (rxf/rd) and

---
 rtl/ftdi_bus_arbiter.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/ftdi_bus_arbiter.sv
// Arbitrates the shared FT245-style byte bus between host reads and buffered FPGA writes.
// Paces rd/wr strobes, inserts turnaround after reads and alternates priority under contention.
module ftdi_bus_arbiter #(
    parameter int TX_AW    = 4,
    parameter int RD_PULSE = 2,
    parameter int WR_PULSE = 2,
    parameter int TURN     = 1
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       rxf,
    input  logic       txe,
    output logic       rd,
    output logic       wr,
    output logic       drv_en,
    output logic [7:0] dq_out,
    input  logic [7:0] dq_in,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy
);

    localparam int DEPTH = 1 << TX_AW;
    localparam int MAX_RW = (RD_PULSE > WR_PULSE) ? RD_PULSE : WR_PULSE;
    localparam int MAX_P = (MAX_RW > TURN) ? MAX_RW : TURN;
    localparam int CW = $clog2(MAX_P + 1);
    localparam logic [CW-1:0] RD_LOAD = CW'(RD_PULSE - 1);
    localparam logic [CW-1:0] WR_LOAD = CW'(WR_PULSE - 1);
    localparam logic [CW-1:0] TURN_LOAD = CW'(TURN - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_LOW,
        RD_DONE,
        TURNA,
        WR_SETUP,
        WR_LOW,
        WR_REL
    } state_t;

    state_t state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic prio_tx;
    logic grant_rd, grant_wr;
    logic rx_req, tx_req;
    logic rd_sample;

    logic [7:0] mem [DEPTH];
    logic [TX_AW:0] wr_ptr, rd_ptr;
    logic fifo_empty, fifo_full;
    logic push, pop;

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[TX_AW-1:0] == rd_ptr[TX_AW-1:0]) &&
                        (wr_ptr[TX_AW] != rd_ptr[TX_AW]);
    assign push = tx_valid & ~fifo_full;
    assign pop  = (state == WR_REL) & ~fifo_empty;

    assign rx_req = ~rxf;
    assign tx_req = ~txe & ~fifo_empty;
    assign rd_sample = (state == RD_LOW) && (cnt == '0);

    assign rd       = (state != RD_LOW);
    assign wr       = (state != WR_LOW);
    assign drv_en   = (state == WR_SETUP) || (state == WR_LOW) || (state == WR_REL);
    assign rx_valid = (state == RD_DONE);
    assign busy     = (state != IDLE);
    assign tx_ready = ~fifo_full;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[TX_AW-1:0]] <= tx_data;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state   <= IDLE;
            cnt     <= '0;
            prio_tx <= 1'b0;
            dq_out  <= '0;
            rx_data <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (grant_rd) begin
                prio_tx <= 1'b1;
            end else if (grant_wr) begin
                prio_tx <= 1'b0;
            end
            // The head byte is latched at grant and held until the write releases.
            if (grant_wr) begin
                dq_out <= mem[rd_ptr[TX_AW-1:0]];
            end
            if (rd_sample) begin
                rx_data <= dq_in;
            end
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        grant_rd   = 1'b0;
        grant_wr   = 1'b0;
        case (state)
            IDLE: begin
                if (rx_req && (!tx_req || !prio_tx)) begin
                    state_next = RD_LOW;
                    cnt_next   = RD_LOAD;
                    grant_rd   = 1'b1;
                end else if (tx_req) begin
                    state_next = WR_SETUP;
                    grant_wr   = 1'b1;
                end
            end
            RD_LOW: begin
                if (cnt == '0) begin
                    state_next = RD_DONE;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            RD_DONE: begin
                state_next = TURNA;
                cnt_next   = TURN_LOAD;
            end
            TURNA: begin
                if (cnt == '0) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            WR_SETUP: begin
                state_next = WR_LOW;
                cnt_next   = WR_LOAD;
            end
            WR_LOW: begin
                if (cnt == '0) begin
                    state_next = WR_REL;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            WR_REL: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule
